pc_sequencer: RTL and testbench

Program-counter sequencer for the 16-bit single-cycle CPU. Owns the PC register and selects each cycle between sequential increment, branch target and jump target, giving the same jump-over-branch priority as the next-PC mux. Adds stall hold, HALT sleep, a one-cycle boot state after reset and an optional single-level interrupt entry/return with a saved return PC. Sits between instruction decode/ALU-compare outputs and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register with jump/branch/increment select, stall hold, HALT sleep,
// one-cycle boot state and optional single-level interrupt entry/return (enabled by PC_SEQ_IRQ_EN).
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] IRQ_VEC   = 16'h0010,
    parameter logic [15:0] PC_STEP   = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [15:0] Branch_Target,
    input  logic        Jump_sel,
    input  logic [15:0] Jump_Target,
    input  logic        irq_req,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        irq_ack,
    output logic [15:0] epc,
    output logic        int_en
);

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] epc_q, epc_d;
    logic        int_en_q, int_en_d;
    logic        irq_ack_q, irq_ack_d;

    logic        irq_take;
    logic [15:0] pc_inc;
    logic [15:0] seq_next;

    assign irq_take = IRQ_EN && irq_req && int_en_q;
    assign pc_inc   = pc_q + PC_STEP;

    // Address the program would fetch next absent an interrupt; halt keeps the PC so a
    // HALT interrupted in RUN is re-executed after reti.
    always_comb begin
        seq_next = pc_inc;
        if (halt)
            seq_next = pc_q;
        else if (IRQ_EN && reti)
            seq_next = epc_q;
        else if (Jump_sel)
            seq_next = Jump_Target;
        else if (branch_taken)
            seq_next = Branch_Target;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        int_en_d  = int_en_q;
        irq_ack_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (irq_take) begin
                        pc_d      = IRQ_VEC;
                        epc_d     = seq_next;
                        int_en_d  = 1'b0;
                        irq_ack_d = 1'b1;
                    end else begin
                        if (halt)
                            state_d = ST_HALTED;
                        pc_d = seq_next;
                        if (IRQ_EN && reti && !halt)
                            int_en_d = 1'b1;
                        if (IRQ_EN && di)
                            int_en_d = 1'b0;
                        else if (IRQ_EN && ei)
                            int_en_d = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (irq_take) begin
                    pc_d      = IRQ_VEC;
                    epc_d     = pc_inc;
                    int_en_d  = 1'b0;
                    irq_ack_d = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VEC;
            epc_q     <= 16'h0000;
            int_en_q  <= 1'b0;
            irq_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            int_en_q  <= int_en_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign irq_ack  = irq_ack_q;
    assign epc      = epc_q;
    assign int_en   = int_en_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; interrupt scenarios follow PC_SEQ_IRQ_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, branch_taken, Jump_sel, irq_req, ei, di, reti;
    logic [15:0] Branch_Target, Jump_Target;
    logic [15:0] pc, epc;
    logic        pc_valid, irq_ack, int_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .Branch_Target(Branch_Target),
        .Jump_sel(Jump_sel), .Jump_Target(Jump_Target),
        .irq_req(irq_req), .ei(ei), .di(di), .reti(reti),
        .pc(pc), .pc_valid(pc_valid), .irq_ack(irq_ack), .epc(epc), .int_en(int_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; branch_taken = 0; Jump_sel = 0; irq_req = 0;
        ei = 0; di = 0; reti = 0; Branch_Target = 16'h0; Jump_Target = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", pc_valid); end
        n_checks++; if ({irq_ack, int_en, epc} !== 18'h0) begin n_fail++; $display("FAIL reset_irq got ack=%b en=%b epc=%h want 0/0/0000", irq_ack, int_en, epc); end
        step();
        rst_n = 1;
        n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b want 0", pc_valid); end
        step();
        n_checks++; if (pc_valid !== 1'b1 || pc !== 16'h0000) begin n_fail++; $display("FAIL first_fetch got v=%b pc=%h want 1/0000", pc_valid, pc); end
        step();
        n_checks++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL incr1 got %h want 0001", pc); end
        step();
        n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL incr2 got %h want 0002", pc); end
    endtask

    task automatic test_wrap();
        Jump_sel = 1; Jump_Target = 16'hFFFF;
        step();
        n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_jump got %h want FFFF", pc); end
        Jump_sel = 0;
        step();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap got %h want 0000", pc); end
    endtask

    task automatic test_jump_branch();
        Jump_sel = 1; Jump_Target = 16'hAAAA; branch_taken = 1; Branch_Target = 16'h5555;
        step();
        n_checks++; if (pc !== 16'hAAAA) begin n_fail++; $display("FAIL jump_prio got %h want AAAA", pc); end
        Jump_sel = 0;
        step();
        n_checks++; if (pc !== 16'h5555) begin n_fail++; $display("FAIL branch got %h want 5555", pc); end
        branch_taken = 0;
        step();
        n_checks++; if (pc !== 16'h5556) begin n_fail++; $display("FAIL post_branch got %h want 5556", pc); end
    endtask

    task automatic test_stall();
        stall = 1; Jump_sel = 1; Jump_Target = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc !== 16'h5556 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d got pc=%h v=%b want 5556/1", i, pc, pc_valid); end
        end
        stall = 0;
        step();
        n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL stall_release got %h want 1234", pc); end
        Jump_sel = 0;
    endtask

    task automatic test_irq();
        Jump_sel = 1; Jump_Target = 16'h0020; ei = 1;
        step();
        Jump_sel = 0; ei = 0;
        n_checks++; if (pc !== 16'h0020) begin n_fail++; $display("FAIL irq_setup got %h want 0020", pc); end
        irq_req = 1; branch_taken = 1; Branch_Target = 16'h0040;
        step();
        irq_req = 0; branch_taken = 0;
`ifdef PC_SEQ_IRQ_EN
        n_checks++; if (pc !== 16'h0010 || epc !== 16'h0040) begin n_fail++; $display("FAIL irq_entry got pc=%h epc=%h want 0010/0040", pc, epc); end
        n_checks++; if (irq_ack !== 1'b1 || int_en !== 1'b0) begin n_fail++; $display("FAIL irq_ack got ack=%b en=%b want 1/0", irq_ack, int_en); end
        step();
        n_checks++; if (irq_ack !== 1'b0 || pc !== 16'h0011) begin n_fail++; $display("FAIL irq_pulse got ack=%b pc=%h want 0/0011", irq_ack, pc); end
        reti = 1;
        step();
        reti = 0;
        n_checks++; if (pc !== 16'h0040 || int_en !== 1'b1) begin n_fail++; $display("FAIL reti got pc=%h en=%b want 0040/1", pc, int_en); end
`else
        n_checks++; if (pc !== 16'h0040 || epc !== 16'h0000) begin n_fail++; $display("FAIL irq_ignored got pc=%h epc=%h want 0040/0000", pc, epc); end
        n_checks++; if (irq_ack !== 1'b0 || int_en !== 1'b0) begin n_fail++; $display("FAIL irq_off got ack=%b en=%b want 0/0", irq_ack, int_en); end
        reti = 1;
        step();
        reti = 0;
        n_checks++; if (pc !== 16'h0041 || int_en !== 1'b0) begin n_fail++; $display("FAIL reti_noop got pc=%h en=%b want 0041/0", pc, int_en); end
`endif
    endtask

    task automatic test_halt();
        Jump_sel = 1; Jump_Target = 16'h0030; ei = 1;
        step();
        Jump_sel = 0; ei = 0;
        halt = 1;
        step();
        halt = 0;
        n_checks++; if (pc !== 16'h0030 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt got pc=%h v=%b want 0030/0", pc, pc_valid); end
        Jump_sel = 1; Jump_Target = 16'h7777;
        step();
        Jump_sel = 0;
        n_checks++; if (pc !== 16'h0030 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_hold got pc=%h v=%b want 0030/0", pc, pc_valid); end
        irq_req = 1;
        step();
        irq_req = 0;
`ifdef PC_SEQ_IRQ_EN
        n_checks++; if (pc !== 16'h0010 || epc !== 16'h0031 || pc_valid !== 1'b1 || irq_ack !== 1'b1) begin n_fail++; $display("FAIL halt_wake got pc=%h epc=%h v=%b ack=%b want 0010/0031/1/1", pc, epc, pc_valid, irq_ack); end
`else
        n_checks++; if (pc !== 16'h0030 || pc_valid !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL halt_terminal got pc=%h v=%b ack=%b want 0030/0/0", pc, pc_valid, irq_ack); end
`endif
    endtask

    task automatic test_reset_mid();
        rst_n = 0;
        #1;
        n_checks++; if (pc !== 16'h0000 || int_en !== 1'b0 || irq_ack !== 1'b0 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got pc=%h en=%b ack=%b v=%b want 0000/0/0/0", pc, int_en, irq_ack, pc_valid); end
        step();
        rst_n = 1;
        step();
        n_checks++; if (pc !== 16'h0000 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_boot got pc=%h v=%b want 0000/1", pc, pc_valid); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_jump_branch();
        test_stall();
        test_irq();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
